// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature decoder: 2-flop synchronizers, 4x decode, wrapping position,
// saturating windowed velocity. Define QENC_GLITCH_FILTER_EN to add a FILT_LEN-sample input filter.
module quad_encoder_array #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 32,
    parameter int VEL_W      = 16,
    parameter int WIN_CYCLES = 100000,
    parameter int FILT_LEN   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_en,
    input  logic [N_CH-1:0]          i_chA,
    input  logic [N_CH-1:0]          i_chB,
    input  logic [N_CH-1:0]          i_clr_pos,
    input  logic                     i_err_clr,
    output logic [N_CH*CNT_W-1:0]    o_pos,
    output logic [N_CH*VEL_W-1:0]    o_vel,
    output logic                     o_vel_valid,
    output logic [N_CH-1:0]          o_dir,
    output logic [N_CH-1:0]          o_err
);

    localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic signed [VEL_W-1:0] VEL_MAX = {1'b0, {(VEL_W-1){1'b1}}};
    localparam logic signed [VEL_W-1:0] VEL_MIN = -VEL_MAX;
    localparam logic signed [VEL_W-1:0] VEL_ONE = 1;
    localparam logic [CNT_W-1:0]        POS_ONE = 1;

    if (N_CH < 1 || N_CH > 8 || WIN_CYCLES < 2 || FILT_LEN < 1 || VEL_W < 2) begin : g_bad_param
        $error("quad_encoder_array: parameter out of range");
    end

    // Gray phase {A,B} to a 2-bit position so forward is simply +1 mod 4.
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    logic [N_CH-1:0] a_s1, a_s2, b_s1, b_s2;
    logic [1:0]      prime;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            a_s1  <= '0;
            a_s2  <= '0;
            b_s1  <= '0;
            b_s2  <= '0;
            prime <= '0;
        end else begin
            a_s1  <= i_chA;
            a_s2  <= a_s1;
            b_s1  <= i_chB;
            b_s2  <= b_s1;
            prime <= {prime[0], 1'b1};
        end
    end

    logic [WIN_W-1:0] win_cnt;
    logic             win_tc;

    assign win_tc = i_en && (win_cnt == WIN_W'(WIN_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            win_cnt     <= '0;
            o_vel_valid <= 1'b0;
        end else begin
            o_vel_valid <= win_tc;
            if (!i_en || win_tc) win_cnt <= '0;
            else                 win_cnt <= win_cnt + WIN_W'(1);
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic                    armed;
        logic [1:0]              prev_ab;
        logic                    a_d, b_d;
        logic [1:0]              cur_ab;
        logic                    fwd, rev, bad, up, dn;
        logic [CNT_W-1:0]        pos_q;
        logic signed [VEL_W-1:0] acc_q, acc_nxt, vel_q;
        logic                    dir_q, err_q;

`ifdef QENC_GLITCH_FILTER_EN
        localparam int FC_W = $clog2(FILT_LEN + 1);
        logic            a_f, b_f;
        logic [FC_W-1:0] a_cnt, b_cnt;

        // Until armed the filter tracks the synchronizer directly so start-up needs no settling.
        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                a_f   <= 1'b0;
                b_f   <= 1'b0;
                a_cnt <= '0;
                b_cnt <= '0;
            end else if (!armed) begin
                a_f   <= a_s2[k];
                b_f   <= b_s2[k];
                a_cnt <= '0;
                b_cnt <= '0;
            end else begin
                if (a_s2[k] == a_f) begin
                    a_cnt <= '0;
                end else if (a_cnt == FC_W'(FILT_LEN - 1)) begin
                    a_f   <= a_s2[k];
                    a_cnt <= '0;
                end else begin
                    a_cnt <= a_cnt + FC_W'(1);
                end
                if (b_s2[k] == b_f) begin
                    b_cnt <= '0;
                end else if (b_cnt == FC_W'(FILT_LEN - 1)) begin
                    b_f   <= b_s2[k];
                    b_cnt <= '0;
                end else begin
                    b_cnt <= b_cnt + FC_W'(1);
                end
            end
        end

        assign a_d = a_f;
        assign b_d = b_f;
`else
        assign a_d = a_s2[k];
        assign b_d = b_s2[k];
`endif

        assign cur_ab = {a_d, b_d};

        always_comb begin
            fwd = armed && (gray2bin(cur_ab) == gray2bin(prev_ab) + 2'd1);
            rev = armed && (gray2bin(prev_ab) == gray2bin(cur_ab) + 2'd1);
            bad = armed && (cur_ab == ~prev_ab);
            up  = fwd && i_en && !i_clr_pos[k];
            dn  = rev && i_en && !i_clr_pos[k];
            acc_nxt = acc_q;
            if (up && acc_q != VEL_MAX)      acc_nxt = acc_q + VEL_ONE;
            else if (dn && acc_q != VEL_MIN) acc_nxt = acc_q - VEL_ONE;
        end

        always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
                armed   <= 1'b0;
                prev_ab <= 2'b00;
                pos_q   <= '0;
                acc_q   <= '0;
                vel_q   <= '0;
                dir_q   <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                // Arm only once the synchronizer holds a real sample, never the reset zeros.
                if (!armed) begin
                    if (prime[1]) begin
                        armed   <= 1'b1;
                        prev_ab <= {a_s2[k], b_s2[k]};
                    end
                end else begin
                    prev_ab <= cur_ab;
                end

                if (i_clr_pos[k]) pos_q <= '0;
                else if (up)      pos_q <= pos_q + POS_ONE;
                else if (dn)      pos_q <= pos_q - POS_ONE;

                if (up)      dir_q <= 1'b1;
                else if (dn) dir_q <= 1'b0;

                err_q <= (err_q & ~i_err_clr) | bad;

                if (!i_en) begin
                    acc_q <= '0;
                end else if (win_tc) begin
                    vel_q <= acc_nxt;
                    acc_q <= '0;
                end else begin
                    acc_q <= acc_nxt;
                end
            end
        end

        assign o_pos[k*CNT_W +: CNT_W] = pos_q;
        assign o_vel[k*VEL_W +: VEL_W] = vel_q;
        assign o_dir[k]                = dir_q;
        assign o_err[k]                = err_q;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
// Directed bench for quad_encoder_array: position, latency, errors, clear, windowed velocity,
// saturation, enable gating and mid-stream reset, all against hand-computed values.
module tb_quad_encoder_array;

    localparam int N_CH       = 2;
    localparam int CNT_W      = 32;
    localparam int VEL_W      = 8;
    localparam int WIN_CYCLES = 1000;
    localparam int FILT_LEN   = 4;
`ifdef QENC_GLITCH_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  en;
    logic [N_CH-1:0]       chA, chB, clr_pos;
    logic                  err_clr;
    logic [N_CH*CNT_W-1:0] o_pos;
    logic [N_CH*VEL_W-1:0] o_vel;
    logic                  o_vel_valid;
    logic [N_CH-1:0]       o_dir, o_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [1:0] idx [N_CH];

    quad_encoder_array #(
        .N_CH(N_CH), .CNT_W(CNT_W), .VEL_W(VEL_W),
        .WIN_CYCLES(WIN_CYCLES), .FILT_LEN(FILT_LEN)
    ) dut (
        .i_clk(clk), .i_rstn(rstn), .i_en(en),
        .i_chA(chA), .i_chB(chB), .i_clr_pos(clr_pos), .i_err_clr(err_clr),
        .o_pos(o_pos), .o_vel(o_vel), .o_vel_valid(o_vel_valid),
        .o_dir(o_dir), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    function automatic logic signed [CNT_W-1:0] pos(input int k);
        return o_pos[k*CNT_W +: CNT_W];
    endfunction

    function automatic logic signed [VEL_W-1:0] vel(input int k);
        return o_vel[k*VEL_W +: VEL_W];
    endfunction

    // One quadrature edge; d > 0 is forward (00->01->11->10).
    task automatic step(input int ch, input int d);
        logic [1:0] ix;
        ix = idx[ch] + ((d > 0) ? 2'd1 : 2'd3);
        idx[ch] = ix;
        chA[ch] = ix[1];
        chB[ch] = ix[1] ^ ix[0];
    endtask

    task automatic toggle_both(input int ch);
        idx[ch] = idx[ch] + 2'd2;
        chA[ch] = ~chA[ch];
        chB[ch] = ~chB[ch];
    endtask

    task automatic wait_valid(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick(1);
            if (o_vel_valid) seen = 1'b1;
        end
    endtask

    initial begin
        int  last;
        int  npulse;
        bit  prev_v;
        bit  seen;

        rstn = 1'b0; en = 1'b0; chA = '0; chB = '0; clr_pos = '0; err_clr = 1'b0;
        for (int i = 0; i < N_CH; i++) idx[i] = 2'd0;
        tick(3);
        check("rst_pos0", pos(0), 0);
        check("rst_pos1", pos(1), 0);
        check("rst_vel0", vel(0), 0);
        check("rst_valid", o_vel_valid, 0);
        check("rst_dir", o_dir, 0);
        check("rst_err", o_err, 0);

        rstn = 1'b1;
        tick(5);
        en = 1'b1;

        // 8 full forward cycles on ch0 at 4 clocks per edge
        for (int i = 0; i < 32; i++) begin step(0, 1); tick(4); end
        tick(LAT);
        check("fwd32_pos0", pos(0), 32);
        check("fwd32_dir0", o_dir[0], 1);
        check("fwd32_pos1", pos(1), 0);

        step(0, 1);
        tick(LAT - 1);
        check("lat_before", pos(0), 32);
        tick(1);
        check("lat_after", pos(0), 33);

        // Illegal double change on ch1, clear, then clear coincident with a new illegal
        toggle_both(1);
        tick(LAT + 1);
        check("illegal_err", o_err, 2'b10);
        check("illegal_pos1", pos(1), 0);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_cleared", o_err, 2'b00);
        toggle_both(1);
        tick(LAT - 1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        check("err_set_wins", o_err[1], 1);
        tick(2);
        check("err_sticky", o_err[1], 1);

        // Position clear, then clear coincident with a counted step
        clr_pos = 2'b01; tick(1); clr_pos = '0;
        check("clr_pos0", pos(0), 0);
        for (int i = 0; i < 5; i++) begin step(0, 1); tick(4); end
        tick(LAT);
        check("pos0_five", pos(0), 5);
        step(0, 1);
        tick(LAT - 1);
        clr_pos = 2'b01; tick(1); clr_pos = '0;
        check("clr_step_pos0", pos(0), 0);
        tick(4);
        check("clr_step_disc", pos(0), 0);

        // Disabled: tracking only
        en = 1'b0;
        tick(2);
        step(0, 1);
        tick(LAT + 2);
        check("en0_pos_hold", pos(0), 0);
        check("en0_no_valid", o_vel_valid, 0);

        // Reverse at one edge per 50 clocks: 20 counts per 1000-cycle window
        en = 1'b1;
        last = 0; npulse = 0; prev_v = 1'b0;
        for (int c = 0; c < 3010; c++) begin
            if (c % 50 == 0) step(0, -1);
            tick(1);
            if (prev_v) check("pulse_width", o_vel_valid, 0);
            if (o_vel_valid) begin
                if (npulse == 0) begin
                    check("win_first", c + 1, WIN_CYCLES);
                    check("vel1_idle", vel(1), 0);
                end else begin
                    check("win_period", c + 1 - last, WIN_CYCLES);
                end
                check("vel_rev", vel(0), -20);
                last = c + 1;
                npulse++;
            end
            prev_v = o_vel_valid;
        end
        check("pulse_count", npulse, 3);
        check("rev_pos0", pos(0), -61);
        check("rev_dir0", o_dir[0], 0);

        // 200 forward edges inside one window saturate the 8-bit velocity
        en = 1'b0; clr_pos = 2'b01; tick(1); clr_pos = '0;
        en = 1'b1;
        for (int i = 0; i < 200; i++) begin step(0, 1); tick(4); end
        wait_valid(500, seen);
        check("sat_valid_seen", seen, 1);
        check("sat_vel0", vel(0), 127);
        check("sat_pos0", pos(0), 200);

        // Mid-stream reset with ch0 parked at 11
        for (int i = 0; i < 4 && idx[0] != 2'd2; i++) begin step(0, 1); tick(4); end
        rstn = 1'b0;
        #1;
        check("mrst_pos0", pos(0), 0);
        check("mrst_vel0", vel(0), 0);
        check("mrst_dir", o_dir, 0);
        check("mrst_err", o_err, 0);
        check("mrst_valid", o_vel_valid, 0);
        tick(2);
        rstn = 1'b1;
        tick(10);
        check("post_rst_pos0", pos(0), 0);
        check("post_rst_err", o_err, 0);
        step(0, 1);
        tick(LAT + 1);
        check("post_rst_step", pos(0), 1);

        // Simultaneous steps on both channels
        step(0, 1);
        step(1, 1);
        tick(LAT + 1);
        check("simul_pos0", pos(0), 2);
        check("simul_pos1", pos(1), 1);

`ifdef QENC_GLITCH_FILTER_EN
        chA[0] = ~chA[0]; tick(2); chA[0] = ~chA[0];
        tick(12);
        check("glitch_pos0", pos(0), 2);
        check("glitch_err", o_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
